// File: rtl/pid_accum_mc.sv
// Multi-channel incremental-PID output accumulator: u(k) = clamp(u(k-1) + du(k)), with per-channel preset load.
// Latency: 1 cycle from accepted in_valid to out_valid. Throughput is 1 op/cycle on any channel mix.
// Backpressure: none (no ready). freeze=1 blocks accepts and holds all outputs. Option: define PID_ACCUM_SLEW_EN for increment slew limiting.
module pid_accum_mc #(
    parameter int DW       = 15,
    parameter int IW       = 15,
    parameter int CH       = 4,
    parameter int OUT_MIN  = -16384,
    parameter int OUT_MAX  = 16383,
    parameter int SLEW_MAX = 1024,
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [IW-1:0] d_uk,
    input  logic                 preset_en,
    input  logic signed [DW-1:0] preset_val,
    input  logic                 freeze,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic signed [DW-1:0] uk0,
    output logic                 sat_hi,
    output logic                 sat_lo,
`ifdef PID_ACCUM_SLEW_EN
    output logic                 ch_err,
    output logic                 slew_lim
`else
    output logic                 ch_err
`endif
);

    // Reject parameter sets that would break the no-overflow guarantee of the DW+1 sum.
    if (IW > DW || CH < 1 || OUT_MIN > 0 || OUT_MAX < 0 || SLEW_MAX < 0 ||
        OUT_MIN < -(2 ** (DW - 1)) || OUT_MAX > (2 ** (DW - 1)) - 1) begin : g_bad_params
        $error("pid_accum_mc: illegal parameter set");
    end

    // All arithmetic runs at DW+1 bits so a full-range state plus a full-range increment cannot wrap.
    localparam logic signed [DW:0] MIN_W = (DW + 1)'(OUT_MIN);
    localparam logic signed [DW:0] MAX_W = (DW + 1)'(OUT_MAX);
    localparam logic [CHW:0]       CH_W  = (CHW + 1)'(CH);
`ifdef PID_ACCUM_SLEW_EN
    localparam logic signed [DW:0] SLEW_P = (DW + 1)'(SLEW_MAX);
    localparam logic signed [DW:0] SLEW_N = (DW + 1)'(-SLEW_MAX);
`endif

    logic signed [DW-1:0] st_q [CH];
    logic signed [DW-1:0] st_d [CH];

    logic                 out_valid_q, out_valid_d;
    logic [CHW-1:0]       out_ch_q, out_ch_d;
    logic signed [DW-1:0] uk0_q, uk0_d;
    logic                 sat_hi_q, sat_hi_d;
    logic                 sat_lo_q, sat_lo_d;
    logic                 ch_err_q, ch_err_d;
    logic                 slew_lim_q, slew_lim_d;

    logic                 ch_ok;
    logic                 acc;
    logic                 clip;
    logic signed [DW-1:0] cur;
    logic signed [DW:0]   inc;
    logic signed [DW:0]   inc_l;
    logic signed [DW:0]   cur_w;
    logic signed [DW:0]   pre_w;
    logic signed [DW:0]   cand;
    logic                 cand_hi;
    logic                 cand_lo;
    logic signed [DW-1:0] res;

    // Datapath: read the addressed channel, form the candidate, clamp, and compute next register state.
    always_comb begin
        ch_ok = ({1'b0, in_ch} < CH_W);
        acc   = in_valid & ~freeze & ch_ok;

        // Mux rather than direct indexing so an out-of-range in_ch never reads past the array.
        cur = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == CHW'(i)) cur = st_q[i];
        end

        inc   = {{(DW + 1 - IW){d_uk[IW-1]}}, d_uk};
        inc_l = inc;
        clip  = 1'b0;
`ifdef PID_ACCUM_SLEW_EN
        if (inc > SLEW_P) begin
            inc_l = SLEW_P;
            clip  = ~preset_en;
        end else if (inc < SLEW_N) begin
            inc_l = SLEW_N;
            clip  = ~preset_en;
        end
`endif

        cur_w   = {cur[DW-1], cur};
        pre_w   = {preset_val[DW-1], preset_val};
        cand    = preset_en ? pre_w : (cur_w + inc_l);
        cand_hi = (cand > MAX_W);
        cand_lo = (cand < MIN_W);
        // Clamping the stored value (not just the output) is what prevents windup past a limit.
        if (cand_hi)      res = MAX_W[DW-1:0];
        else if (cand_lo) res = MIN_W[DW-1:0];
        else              res = cand[DW-1:0];

        for (int i = 0; i < CH; i++) begin
            st_d[i] = st_q[i];
            if (acc && in_ch == CHW'(i)) st_d[i] = res;
        end

        out_valid_d = acc;
        ch_err_d    = in_valid & ~freeze & ~ch_ok;
        out_ch_d    = out_ch_q;
        uk0_d       = uk0_q;
        sat_hi_d    = sat_hi_q;
        sat_lo_d    = sat_lo_q;
        slew_lim_d  = slew_lim_q;
        if (acc) begin
            out_ch_d   = in_ch;
            uk0_d      = res;
            sat_hi_d   = cand_hi;
            sat_lo_d   = cand_lo;
            slew_lim_d = clip;
        end
    end

    // State and output registers; synchronous reset clears everything including any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) st_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            uk0_q       <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            ch_err_q    <= 1'b0;
            slew_lim_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) st_q[i] <= st_d[i];
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            uk0_q       <= uk0_d;
            sat_hi_q    <= sat_hi_d;
            sat_lo_q    <= sat_lo_d;
            ch_err_q    <= ch_err_d;
            slew_lim_q  <= slew_lim_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign uk0       = uk0_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign ch_err    = ch_err_q;
`ifdef PID_ACCUM_SLEW_EN
    assign slew_lim  = slew_lim_q;
`else
    // The flag is only meaningful with slew limiting; it is always zero here.
    logic unused_slew;
    assign unused_slew = slew_lim_q;
`endif

endmodule

// File: tb/tb_pid_accum_mc.sv
// Self-checking bench for pid_accum_mc: directed scenarios plus a randomized run against a plain-integer model.
// CH=5 is used so that an out-of-range channel (5..7) is representable on the 3-bit in_ch port.
// Works with or without PID_ACCUM_SLEW_EN defined.
module tb_pid_accum_mc;
    localparam int DW   = 15;
    localparam int IW   = 15;
    localparam int CH   = 5;
    localparam int CHW  = 3;
    localparam int OMIN = -16384;
    localparam int OMAX = 16383;
    localparam int SLEW = 1024;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic [CHW-1:0]       in_ch = '0;
    logic signed [IW-1:0] d_uk = '0;
    logic                 preset_en = 1'b0;
    logic signed [DW-1:0] preset_val = '0;
    logic                 freeze = 1'b0;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic signed [DW-1:0] uk0;
    logic                 sat_hi;
    logic                 sat_lo;
    logic                 ch_err;
`ifdef PID_ACCUM_SLEW_EN
    logic                 slew_lim;
`endif

    pid_accum_mc #(
        .DW(DW), .IW(IW), .CH(CH), .OUT_MIN(OMIN), .OUT_MAX(OMAX), .SLEW_MAX(SLEW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .d_uk(d_uk),
        .preset_en(preset_en), .preset_val(preset_val), .freeze(freeze),
        .out_valid(out_valid), .out_ch(out_ch), .uk0(uk0),
        .sat_hi(sat_hi), .sat_lo(sat_lo),
`ifdef PID_ACCUM_SLEW_EN
        .ch_err(ch_err), .slew_lim(slew_lim)
`else
        .ch_err(ch_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: channel values as integers and the expected registered outputs.
    int mst [CH];
    bit e_vld, e_hi, e_lo, e_err, e_slew;
    int e_ch, e_u;

    // Drive one cycle of inputs, advance the model by the behavioural rules, and return after the edge.
    task automatic step(input bit r, input bit v, input int ch, input int d,
                        input bit pre, input int pv, input bit frz);
        int dd;
        int cand;
        @(negedge clk);
        rst = r; in_valid = v; in_ch = CHW'(ch); d_uk = IW'(d);
        preset_en = pre; preset_val = DW'(pv); freeze = frz;
        if (r) begin
            for (int i = 0; i < CH; i++) mst[i] = 0;
            e_vld = 0; e_ch = 0; e_u = 0; e_hi = 0; e_lo = 0; e_err = 0; e_slew = 0;
        end else if (v && !frz && ch < CH) begin
            dd = d;
            e_slew = 0;
`ifdef PID_ACCUM_SLEW_EN
            if (!pre && dd > SLEW) begin dd = SLEW; e_slew = 1; end
            else if (!pre && dd < -SLEW) begin dd = -SLEW; e_slew = 1; end
`endif
            cand  = pre ? pv : mst[ch] + dd;
            e_hi  = (cand > OMAX);
            e_lo  = (cand < OMIN);
            e_u   = e_hi ? OMAX : (e_lo ? OMIN : cand);
            mst[ch] = e_u;
            e_vld = 1; e_ch = ch; e_err = 0;
        end else begin
            e_vld = 0;
            e_err = v && !frz;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 55, 0, 0, 0);
        checks++;
        if ({out_valid, out_ch, uk0, sat_hi, sat_lo, ch_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: vld=%0b ch=%0d uk0=%0d hi=%0b lo=%0b err=%0b, required all zero",
                     out_valid, out_ch, uk0, sat_hi, sat_lo, ch_err);
        end
    endtask

    task automatic test_accumulate();
        int incs [3] = '{100, 200, -50};
        int exps [3] = '{100, 300, 250};
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, incs[i], 0, 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && out_ch === 3'd0 && uk0 === DW'(exps[i]) &&
                  sat_hi === 1'b0 && sat_lo === 1'b0)) begin
                failures++;
                $display("FAIL accumulate[%0d]: vld=%0b ch=%0d uk0=%0d hi=%0b lo=%0b, required vld=1 ch=0 uk0=%0d no sat",
                         i, out_valid, out_ch, uk0, sat_hi, sat_lo, exps[i]);
            end
        end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 10, 0, 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && out_ch === 3'd1 && uk0 === DW'(10 * (i + 1)))) begin
                failures++;
                $display("FAIL interleave_ch1[%0d]: vld=%0b ch=%0d uk0=%0d, required 1/1/%0d",
                         i, out_valid, out_ch, uk0, 10 * (i + 1));
            end
            step(0, 1, 2, -10, 0, 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && out_ch === 3'd2 && uk0 === DW'(-10 * (i + 1)))) begin
                failures++;
                $display("FAIL interleave_ch2[%0d]: vld=%0b ch=%0d uk0=%0d, required 1/2/%0d",
                         i, out_valid, out_ch, uk0, -10 * (i + 1));
            end
        end
    endtask

    task automatic test_preset_sat();
        int pre  [6] = '{1, 0, 0, 1, 0, 0};
        int arg  [6] = '{16000, 1000, -500, -16000, -1000, 700};
        int exps [6] = '{16000, 16383, 15883, -16000, -16384, -15684};
        bit ehi  [6] = '{0, 1, 0, 0, 0, 0};
        bit elo  [6] = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 3, pre[i] ? 77 : arg[i], pre[i] != 0, pre[i] ? arg[i] : 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && out_ch === 3'd3 && uk0 === DW'(exps[i]) &&
                  sat_hi === ehi[i] && sat_lo === elo[i])) begin
                failures++;
                $display("FAIL preset_sat[%0d]: vld=%0b ch=%0d uk0=%0d hi=%0b lo=%0b, required 1/3/%0d hi=%0b lo=%0b",
                         i, out_valid, out_ch, uk0, sat_hi, sat_lo, exps[i], ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_ch_err();
        int held;
        held = e_u;
        step(0, 1, 5, 7, 0, 0, 0);
        checks++;
        if (!(ch_err === 1'b1 && out_valid === 1'b0 && uk0 === DW'(held))) begin
            failures++;
            $display("FAIL ch_err_pulse: err=%0b vld=%0b uk0=%0d, required err=1 vld=0 uk0=%0d",
                     ch_err, out_valid, uk0, held);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ch_err !== 1'b0) begin
            failures++;
            $display("FAIL ch_err_one_cycle: err=%0b, required 0", ch_err);
        end
        for (int c = 0; c < CH; c++) begin
            step(0, 1, c, 0, 0, 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && uk0 === DW'(mst[c]))) begin
                failures++;
                $display("FAIL ch_err_readback[%0d]: vld=%0b uk0=%0d, required vld=1 uk0=%0d",
                         c, out_valid, uk0, mst[c]);
            end
        end
    endtask

    task automatic test_freeze();
        step(0, 1, 0, 0, 1, 50, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, (i == 2) ? 6 : 0, 9, 0, 0, 1);
            checks++;
            if (!(out_valid === 1'b0 && ch_err === 1'b0 && uk0 === 15'sd50 && out_ch === 3'd0)) begin
                failures++;
                $display("FAIL freeze[%0d]: vld=%0b err=%0b uk0=%0d ch=%0d, required 0/0/50/0",
                         i, out_valid, ch_err, uk0, out_ch);
            end
        end
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (!(out_valid === 1'b1 && uk0 === 15'sd50)) begin
            failures++;
            $display("FAIL freeze_readback: vld=%0b uk0=%0d, required 1/50", out_valid, uk0);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 1, 3, 0, 0, 0);
        step(1, 1, 1, 3, 0, 0, 0);
        checks++;
        if (!(out_valid === 1'b0 && uk0 === 15'sd0)) begin
            failures++;
            $display("FAIL reset_mid: vld=%0b uk0=%0d, required 0/0", out_valid, uk0);
        end
        step(0, 1, 2, 5, 0, 0, 0);
        checks++;
        if (!(out_valid === 1'b1 && out_ch === 3'd2 && uk0 === 15'sd5)) begin
            failures++;
            $display("FAIL reset_mid_after: vld=%0b ch=%0d uk0=%0d, required 1/2/5", out_valid, out_ch, uk0);
        end
        step(0, 1, 1, 5, 0, 0, 0);
        checks++;
        if (uk0 !== 15'sd5) begin
            failures++;
            $display("FAIL reset_mid_cleared: uk0=%0d, required 5", uk0);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 4, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 4, 7, 0, 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && uk0 === DW'(7 * i))) begin
                failures++;
                $display("FAIL back_to_back[%0d]: vld=%0b uk0=%0d, required 1/%0d", i, out_valid, uk0, 7 * i);
            end
        end
    endtask

`ifdef PID_ACCUM_SLEW_EN
    task automatic test_slew();
        int pre  [4] = '{0, 0, 0, 1};
        int arg  [4] = '{5000, -300, -5000, 9000};
        int exps [4] = '{1024, 724, -300, 9000};
        bit esl  [4] = '{1, 0, 1, 0};
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, pre[i] ? 0 : arg[i], pre[i] != 0, pre[i] ? arg[i] : 0, 0);
            checks++;
            if (!(out_valid === 1'b1 && uk0 === DW'(exps[i]) && slew_lim === esl[i])) begin
                failures++;
                $display("FAIL slew[%0d]: vld=%0b uk0=%0d slew=%0b, required 1/%0d/%0b",
                         i, out_valid, uk0, slew_lim, exps[i], esl[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int d;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 4000)) - 2000;
            else                           d = int'($urandom_range(0, 32767)) - 16384;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)), d,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 32767)) - 16384,
                 $urandom_range(0, 9) == 0);
            checks++;
            if ({out_valid, out_ch, uk0, sat_hi, sat_lo, ch_err} !==
                {e_vld, CHW'(e_ch), DW'(e_u), e_hi, e_lo, e_err}) begin
                failures++;
                $display("FAIL random[%0d]: vld=%0b ch=%0d uk0=%0d hi=%0b lo=%0b err=%0b, required %0b/%0d/%0d/%0b/%0b/%0b",
                         n, out_valid, out_ch, uk0, sat_hi, sat_lo, ch_err, e_vld, e_ch, e_u, e_hi, e_lo, e_err);
            end
`ifdef PID_ACCUM_SLEW_EN
            checks++;
            if (e_vld && slew_lim !== e_slew) begin
                failures++;
                $display("FAIL random_slew[%0d]: slew=%0b, required %0b", n, slew_lim, e_slew);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_interleave();
        test_preset_sat();
        test_ch_err();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
`ifdef PID_ACCUM_SLEW_EN
        test_slew();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
